divider_result_fifo: RTL and testbench

Result buffer placed directly downstream of the 14-bit pipelined divider. It captures each valid quotient into a circular FIFO and presents the results to the consumer through a ready/valid interface. When the FIFO is full it stalls the divider through the divider's `pause` input, so no result is ever lost or duplicated. An optional compile-time clamp limits stored quotients to a programmable ceiling, such as a screen-coordinate bound.

---
 rtl/divider_result_fifo_if.sv | 25 ++
 rtl/divider_result_fifo.sv | 75 +++++++
 tb/tb_divider_result_fifo.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_result_fifo_if.sv
// rtl/divider_result_fifo_if.sv - handshake bundle between divider, result FIFO and consumer
interface divider_result_fifo_if #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] div_quotient_in;
   logic             div_valid_in;
   logic             div_pause_out;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             ready_in;
   logic [CW-1:0]    count_out;

   modport master (
      output div_quotient_in, div_valid_in, ready_in,
      input  div_pause_out, data_out, valid_out, count_out
   );

   modport slave (
      input  div_quotient_in, div_valid_in, ready_in,
      output div_pause_out, data_out, valid_out, count_out
   );
endinterface

// File: rtl/divider_result_fifo.sv
// rtl/divider_result_fifo.sv - circular result FIFO behind the pipelined divider; DIVQ_CLAMP_EN enables quotient ceiling
module divider_result_fifo #(
   parameter int WIDTH     = 14,
   parameter int DEPTH     = 8,
   parameter int CLAMP_MAX = 1023
) (
   input logic                  clk_in,
   input logic                  rst_in,
   divider_result_fifo_if.slave bus
);
   localparam int               AW         = $clog2(DEPTH);
   localparam int               CW         = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);
   localparam logic [WIDTH-1:0] CLAMP_Q    = WIDTH'(CLAMP_MAX);
`ifdef DIVQ_CLAMP_EN
   localparam bit               CLAMP_ON   = 1'b1;
`else
   localparam bit               CLAMP_ON   = 1'b0;
`endif

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] push_data;

   // Flow control decoded from registered occupancy only; a paused divider holds its result, so capture only when unpaused
   always_comb begin
      full      = (count == FULL_COUNT);
      not_empty = (count != '0);
      push      = bus.div_valid_in && !full;
      pop       = not_empty && bus.ready_in;
      push_data = bus.div_quotient_in;
      if (CLAMP_ON && (bus.div_quotient_in > CLAMP_Q)) begin
         push_data = CLAMP_Q;
      end
   end

   assign bus.div_pause_out = full;
   assign bus.valid_out     = not_empty;
   assign bus.data_out      = not_empty ? mem[rd_ptr] : '0;
   assign bus.count_out     = count;

   // Pointers wrap naturally at DEPTH; occupancy kept separately so full and empty are unambiguous
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array is not reset; results arriving during reset are dropped
   always_ff @(posedge clk_in) begin
      if (rst_in && push) begin
         mem[wr_ptr] <= push_data;
      end
   end
endmodule

// File: tb/tb_divider_result_fifo.sv
// tb/tb_divider_result_fifo.sv - directed self-checking bench for divider_result_fifo
module tb_divider_result_fifo;
   localparam int WIDTH = 14;
   localparam int DEPTH = 8;
`ifdef DIVQ_CLAMP_EN
   localparam int EXP_HI = 1023;
`else
   localparam int EXP_HI = 16383;
`endif

   logic clk_in = 1'b0;
   logic rst_in;
   int   errors = 0;
   int   checks = 0;

   divider_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   divider_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLAMP_MAX(1023)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   // Occupancy must stay within 0..DEPTH (wrap below zero shows up as a large value)
   always @(negedge clk_in) begin
      if (rst_in === 1'b1 && bus.count_out > DEPTH) begin
         errors++;
         $display("FAIL occupancy_bound: count_out=%0d limit=%0d", bus.count_out, DEPTH);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      bus.div_valid_in = 1'b1;
      bus.div_quotient_in = 14'd55;
      bus.ready_in = 1'b0;
      tick(); tick(); tick();
      checks++; if (bus.count_out !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
      checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
      checks++; if (bus.div_pause_out !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b expected 0", bus.div_pause_out); end
      checks++; if (bus.data_out !== 0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.data_out); end
      bus.div_valid_in = 1'b0;
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bus.ready_in = 1'b1;
      bus.div_quotient_in = 14'd37;
      bus.div_valid_in = 1'b1;
      tick();
      bus.div_valid_in = 1'b0;
      checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 37) begin errors++; $display("FAIL single_out: got valid=%b data=%0d expected valid=1 data=37", bus.valid_out, bus.data_out); end
      tick();
      checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL single_once: got valid=%b expected 0", bus.valid_out); end
      checks++; if (bus.count_out !== 0) begin errors++; $display("FAIL single_count: got %0d expected 0", bus.count_out); end
   endtask

   task automatic test_fill();
      logic [WIDTH-1:0] got [$];
      bus.ready_in = 1'b0;
      for (int v = 1; v <= 8; v++) begin
         bus.div_quotient_in = 14'(v);
         bus.div_valid_in = 1'b1;
         tick();
      end
      checks++; if (bus.div_pause_out !== 1'b1) begin errors++; $display("FAIL fill_pause: got %b expected 1", bus.div_pause_out); end
      checks++; if (bus.count_out !== 8) begin errors++; $display("FAIL fill_count: got %0d expected 8", bus.count_out); end
      bus.div_quotient_in = 14'd9;
      tick(); tick(); tick();
      checks++; if (bus.count_out !== 8 || bus.data_out !== 1) begin errors++; $display("FAIL fill_hold: got count=%0d head=%0d expected count=8 head=1", bus.count_out, bus.data_out); end
      bus.ready_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.valid_out === 1'b1) got.push_back(bus.data_out);
         tick();
         if (i == 0) begin
            checks++; if (bus.div_pause_out !== 1'b0) begin errors++; $display("FAIL fill_release: got %b expected 0", bus.div_pause_out); end
         end
         if (i == 1) bus.div_valid_in = 1'b0;
      end
      checks++; if (got.size() != 9) begin errors++; $display("FAIL fill_size: got %0d expected 9", got.size()); end
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (j >= got.size() || got[j] !== 14'(j + 1)) begin
            errors++;
            $display("FAIL fill_order[%0d]: got %0d expected %0d", j, (j < got.size()) ? got[j] : 14'h0, j + 1);
         end
      end
   endtask

   task automatic test_simultaneous();
      bus.ready_in = 1'b0;
      for (int v = 10; v <= 12; v++) begin
         bus.div_quotient_in = 14'(v);
         bus.div_valid_in = 1'b1;
         tick();
      end
      checks++; if (bus.count_out !== 3) begin errors++; $display("FAIL simul_start: got %0d expected 3", bus.count_out); end
      bus.ready_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.div_quotient_in = 14'(13 + k);
         checks++; if (bus.data_out !== 14'(10 + k)) begin errors++; $display("FAIL simul_head[%0d]: got %0d expected %0d", k, bus.data_out, 10 + k); end
         tick();
         checks++; if (bus.count_out !== 3) begin errors++; $display("FAIL simul_count[%0d]: got %0d expected 3", k, bus.count_out); end
      end
      bus.div_valid_in = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 14'(30 + j)) begin errors++; $display("FAIL simul_drain[%0d]: got valid=%b data=%0d expected %0d", j, bus.valid_out, bus.data_out, 30 + j); end
         tick();
      end
      checks++; if (bus.count_out !== 0) begin errors++; $display("FAIL simul_empty: got %0d expected 0", bus.count_out); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] q;
      bus.ready_in = 1'b1;
      for (int k = 0; k < 100; k++) begin
         q = 14'((k * 113 + 7) % 16384);
         bus.div_quotient_in = q;
         bus.div_valid_in = 1'b1;
         tick();
         checks++;
         if (bus.div_pause_out !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== q) begin
            errors++;
            $display("FAIL stream[%0d]: got pause=%b valid=%b data=%0d expected pause=0 valid=1 data=%0d", k, bus.div_pause_out, bus.valid_out, bus.data_out, q);
         end
      end
      bus.div_valid_in = 1'b0;
      tick();
      checks++; if (bus.count_out !== 0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL stream_end: got count=%0d valid=%b expected 0/0", bus.count_out, bus.valid_out); end
   endtask

   task automatic test_reset_mid();
      bit leaked = 1'b0;
      bus.ready_in = 1'b0;
      for (int v = 0; v < 5; v++) begin
         bus.div_quotient_in = 14'(100 + v);
         bus.div_valid_in = 1'b1;
         tick();
      end
      checks++; if (bus.count_out !== 5 || bus.div_pause_out !== 1'b0) begin errors++; $display("FAIL midrst_pre: got count=%0d pause=%b expected 5/0", bus.count_out, bus.div_pause_out); end
      rst_in = 1'b0;
      bus.div_quotient_in = 14'd200;
      tick();
      bus.div_quotient_in = 14'd201;
      tick();
      rst_in = 1'b1;
      bus.div_valid_in = 1'b0;
      checks++; if (bus.count_out !== 0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.count_out); end
      checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.valid_out); end
      checks++; if (bus.div_pause_out !== 1'b0) begin errors++; $display("FAIL midrst_pause: got %b expected 0", bus.div_pause_out); end
      bus.ready_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (bus.valid_out !== 1'b0) leaked = 1'b1;
         tick();
      end
      checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL midrst_leak: got output after reset expected none"); end
      bus.div_quotient_in = 14'd77;
      bus.div_valid_in = 1'b1;
      tick();
      bus.div_valid_in = 1'b0;
      checks++; if (bus.valid_out !== 1'b1 || bus.data_out !== 77) begin errors++; $display("FAIL midrst_resume: got valid=%b data=%0d expected 1/77", bus.valid_out, bus.data_out); end
      tick();
   endtask

   task automatic test_clamp();
      bus.ready_in = 1'b1;
      bus.div_quotient_in = 14'h3FFF;
      bus.div_valid_in = 1'b1;
      tick();
      checks++; if (bus.data_out !== 14'(EXP_HI)) begin errors++; $display("FAIL clamp_hi: got %0d expected %0d", bus.data_out, EXP_HI); end
      bus.div_quotient_in = 14'd500;
      tick();
      bus.div_valid_in = 1'b0;
      checks++; if (bus.data_out !== 500) begin errors++; $display("FAIL clamp_pass: got %0d expected 500", bus.data_out); end
      tick();
      checks++; if (bus.count_out !== 0) begin errors++; $display("FAIL clamp_empty: got %0d expected 0", bus.count_out); end
   endtask

   initial begin
      rst_in = 1'b0;
      bus.div_quotient_in = '0;
      bus.div_valid_in = 1'b0;
      bus.ready_in = 1'b0;
      #1;
      test_reset();
      test_single();
      test_fill();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_clamp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
